mux_pipe_n: RTL

Parametrised, pipelined N:1 data selector with a valid/ready handshake. It generalises the combinational 64:1 single-bit selector to DW-bit words and any power-of-two input count. The tree is built from registered radix-4 levels, so the datapath sustains one selection per clock at the multiplier's operand-steering clock rate. It sits between the operand/partial-product generators and the accuracy-control logic of the approximate multiplier, where wide input vectors are steered by a runtime select.

---
 rtl/mux_pkg.sv | 28 ++
 rtl/mux_stage.sv | 59 +++++
 rtl/mux_pipe_n.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared sizing helpers for the pipelined N:1 selector tree.
package mux_pkg;

    // Nominal reduction factor of one tree level.
    localparam int unsigned MUX_RADIX = 4;

    // Number of registered levels needed to consume a select of width sel_w.
    function automatic int unsigned mux_levels(input int unsigned sel_w);
        return (sel_w + 1) / 2;
    endfunction

    // Candidate count remaining after level k (0-based) has reduced its input.
    // Every level is radix-4 except a final radix-2 level for an odd select width.
    function automatic int unsigned level_cands(input int unsigned n_in, input int unsigned k);
        int unsigned c;
        c = n_in;
        for (int unsigned i = 0; i <= k; i++) begin
            c = (c >= MUX_RADIX) ? c / MUX_RADIX : 1;
        end
        return c;
    endfunction

    // Radix of level k: 4 while two select bits remain for it, otherwise 2.
    function automatic int unsigned level_radix(input int unsigned sel_w, input int unsigned k);
        return (2 * k + 2 <= sel_w) ? MUX_RADIX : 2;
    endfunction

endpackage

// File: rtl/mux_stage.sv
// One registered level of the selector tree: picks one word out of every group of RADIX
// candidates using the low select slice, and carries the unconsumed select bits forward.
module mux_stage
    import mux_pkg::*;
#(
    parameter int unsigned N_CAND  = 4,
    parameter int unsigned RADIX   = MUX_RADIX,
    parameter int unsigned DW      = 1,
    parameter int unsigned REM_W   = 0,
    localparam int unsigned SLICE_W = (RADIX == 4) ? 2 : 1,
    localparam int unsigned N_OUT   = N_CAND / RADIX,
    localparam int unsigned HI_W    = (REM_W > 0) ? REM_W : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  adv_i,
    input  logic                  valid_i,
    input  logic [N_CAND*DW-1:0]  cand_i,
    input  logic [SLICE_W-1:0]    sel_lo_i,
    input  logic [HI_W-1:0]       sel_hi_i,
    output logic                  valid_o,
    output logic [N_OUT*DW-1:0]   cand_o,
    output logic [HI_W-1:0]       sel_hi_o
);

    logic [N_OUT*DW-1:0] cand_d, cand_q;
    logic [HI_W-1:0]     sel_hi_d, sel_hi_q;
    logic                valid_d, valid_q;
    logic [31:0]         lo_idx;

    // Group j holds input words j*RADIX .. j*RADIX+RADIX-1; the low slice picks within it.
    always_comb begin
        cand_d   = '0;
        lo_idx   = 32'(sel_lo_i);
        sel_hi_d = sel_hi_i;
        valid_d  = valid_i;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            cand_d[j*DW +: DW] = cand_i[(j * RADIX + lo_idx) * DW +: DW];
        end
    end

    // Level register: clears on reset, loads only when the whole pipe advances.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            cand_q   <= '0;
            sel_hi_q <= '0;
        end else if (adv_i) begin
            valid_q  <= valid_d;
            cand_q   <= cand_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    assign valid_o  = valid_q;
    assign cand_o   = cand_q;
    assign sel_hi_o = sel_hi_q;

endmodule

// File: rtl/mux_pipe_n.sv
// Pipelined N_IN:1 word selector with a valid/ready handshake. The tree is a chain of
// registered radix-4 levels (radix-2 last level for odd select widths) that all advance
// together; a stall freezes every slot, bubbles included.
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int unsigned N_IN  = 64,
    parameter int unsigned DW    = 1,
    localparam int unsigned SEL_W = $clog2(N_IN),
    localparam int unsigned L     = mux_levels(SEL_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN*DW-1:0]   a,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        y,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic adv;

    // The pipe moves whenever the output slot is empty or being drained this cycle.
    always_comb begin
        adv = !out_valid || out_ready;
    end

    assign in_ready = adv;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int unsigned RADIX   = level_radix(SEL_W, k);
        localparam int unsigned SLICE_W = (RADIX == 4) ? 2 : 1;
        localparam int unsigned SW_IN   = SEL_W - 2 * k;
        localparam int unsigned REM_W   = SW_IN - SLICE_W;
        localparam int unsigned HI_W    = (REM_W > 0) ? REM_W : 1;
        localparam int unsigned NC_OUT  = level_cands(N_IN, k);
        localparam int unsigned NC_IN   = NC_OUT * RADIX;

        logic [NC_IN*DW-1:0]  cand_in;
        logic [SLICE_W-1:0]   sel_lo;
        logic [HI_W-1:0]      sel_hi;
        logic                 valid_in;
        logic [NC_OUT*DW-1:0] cand_out;
        logic [HI_W-1:0]      sel_hi_out;
        logic                 valid_out;

        if (k == 0) begin : g_src
            assign cand_in  = a;
            assign valid_in = in_valid;
            assign sel_lo   = sel[SLICE_W-1:0];
            if (REM_W > 0) begin : g_hi
                assign sel_hi = sel[SEL_W-1:SLICE_W];
            end else begin : g_nohi
                assign sel_hi = '0;
            end
        end else begin : g_chain
            // The previous level always left SW_IN select bits, all carried in its sel_hi_out.
            assign cand_in  = g_lvl[k-1].cand_out;
            assign valid_in = g_lvl[k-1].valid_out;
            assign sel_lo   = g_lvl[k-1].sel_hi_out[SLICE_W-1:0];
            if (REM_W > 0) begin : g_hi
                assign sel_hi = g_lvl[k-1].sel_hi_out[SW_IN-1:SLICE_W];
            end else begin : g_nohi
                assign sel_hi = '0;
            end
        end

        mux_stage #(
            .N_CAND (NC_IN),
            .RADIX  (RADIX),
            .DW     (DW),
            .REM_W  (REM_W)
        ) u_stage (
            .clk_i    (clk),
            .rst_i    (rst),
            .adv_i    (adv),
            .valid_i  (valid_in),
            .cand_i   (cand_in),
            .sel_lo_i (sel_lo),
            .sel_hi_i (sel_hi),
            .valid_o  (valid_out),
            .cand_o   (cand_out),
            .sel_hi_o (sel_hi_out)
        );
    end

    // The last level has exactly one candidate left: that is the output word.
    assign y         = g_lvl[L-1].cand_out;
    assign out_valid = g_lvl[L-1].valid_out;

endmodule
